// File: rtl/itcm_port_arbiter.sv
// Purpose : shares one single-port ITCM RAM between fetch (A) and loader/LSU (B), round-robin, byte-masked writes via RMW.
// Latency : reads and full/zero-mask writes respond 1 cycle after accept; partial-mask writes respond 2 cycles after accept.
// Backpr. : cmd_ready goes only to the granted port and drops on both ports in the MERGE cycle; responses cannot be stalled.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   {a,b}_cmd_*              per-port command (valid/ready, read, addr, wdata, wmask)
//   {a,b}_rsp_valid/_rdata   per-port one-cycle response pulse and read data
//   ram_addr/_wr_data/_wr_en RAM command side
//   ram_rd_data              RAM read data, one cycle after address
module itcm_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_cmd_valid,
    output logic                  a_cmd_ready,
    input  logic                  a_cmd_read,
    input  logic [ADDR_WIDTH-1:0] a_cmd_addr,
    input  logic [DATA_WIDTH-1:0] a_cmd_wdata,
    input  logic [MASK_WIDTH-1:0] a_cmd_wmask,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_cmd_valid,
    output logic                  b_cmd_ready,
    input  logic                  b_cmd_read,
    input  logic [ADDR_WIDTH-1:0] b_cmd_addr,
    input  logic [DATA_WIDTH-1:0] b_cmd_wdata,
    input  logic [MASK_WIDTH-1:0] b_cmd_wmask,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    last_grant_q;   // 1 = port B was granted last
    logic [ADDR_WIDTH-1:0]   hold_addr_q;
    logic [DATA_WIDTH-1:0]   hold_wdata_q;
    logic [MASK_WIDTH-1:0]   hold_wmask_q;
    logic                    hold_port_q;    // 1 = pending merge belongs to port B
    logic [ADDR_WIDTH-1:0]   last_addr_q;    // keeps ram_addr quiet on idle cycles
    logic                    a_rsp_valid_q;
    logic                    b_rsp_valid_q;

    logic                    idle_ok;
    logic                    merge_act;
    logic                    grant_a;
    logic                    grant_b;
    logic                    accept;
    logic                    sel_read;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [MASK_WIDTH-1:0]   sel_wmask;
    logic                    mask_full;
    logic                    mask_zero;
    logic                    start_rmw;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    a_rsp_valid_d;
    logic                    b_rsp_valid_d;

    // rst_n is folded in so nothing is granted or written while reset is held.
    assign idle_ok   = rst_n && (state_q == IDLE);
    assign merge_act = rst_n && (state_q == MERGE);

    // Tie goes to the port that was not granted last.
    assign grant_a = idle_ok & a_cmd_valid & (~b_cmd_valid | last_grant_q);
    assign grant_b = idle_ok & b_cmd_valid & ~grant_a;
    assign accept  = grant_a | grant_b;

    assign a_cmd_ready = grant_a;
    assign b_cmd_ready = grant_b;

    assign sel_read  = grant_b ? b_cmd_read  : a_cmd_read;
    assign sel_addr  = grant_b ? b_cmd_addr  : a_cmd_addr;
    assign sel_wdata = grant_b ? b_cmd_wdata : a_cmd_wdata;
    assign sel_wmask = grant_b ? b_cmd_wmask : a_cmd_wmask;

    assign mask_full = &sel_wmask;
    assign mask_zero = ~|sel_wmask;
    assign start_rmw = accept & ~sel_read & ~mask_full & ~mask_zero;

    // Old word arrives on ram_rd_data in the MERGE cycle; overlay the held bytes.
    always_comb begin
        merged = ram_rd_data;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (hold_wmask_q[i]) begin
                merged[8*i +: 8] = hold_wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        ram_addr    = last_addr_q;
        ram_wr_data = sel_wdata;
        ram_wr_en   = 1'b0;
        if (merge_act) begin
            ram_addr    = hold_addr_q;
            ram_wr_data = merged;
            ram_wr_en   = 1'b1;
        end else if (accept) begin
            // A partial write issues a plain read here; mask-zero writes touch nothing.
            ram_addr  = sel_addr;
            ram_wr_en = ~sel_read & mask_full;
        end
    end

    // Partial writes answer after the MERGE cycle instead of after accept.
    assign a_rsp_valid_d = (grant_a & ~start_rmw) | (merge_act & ~hold_port_q);
    assign b_rsp_valid_d = (grant_b & ~start_rmw) | (merge_act &  hold_port_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            hold_wmask_q  <= '0;
            hold_port_q   <= 1'b0;
            last_addr_q   <= '0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
        end else begin
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            last_addr_q   <= ram_addr;
            if (accept) begin
                last_grant_q <= grant_b;
            end
            if (start_rmw) begin
                state_q      <= MERGE;
                hold_addr_q  <= sel_addr;
                hold_wdata_q <= sel_wdata;
                hold_wmask_q <= sel_wmask;
                hold_port_q  <= grant_b;
            end else begin
                state_q      <= IDLE;
            end
        end
    end

    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_rdata = ram_rd_data;
    assign b_rsp_rdata = ram_rd_data;

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Purpose : self-checking bench for itcm_port_arbiter with a behavioural RAM and a shadow-memory reference model.
// Latency : model predicts response cycle per command (accept+1, or accept+2 for partial-mask writes).
// Backpr. : model predicts which port is granted each cycle and blocks both during the merge cycle.
module tb_itcm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [11:0] a_cmd_addr;
    logic [63:0] a_cmd_wdata;
    logic [7:0]  a_cmd_wmask;
    logic        a_rsp_valid;
    logic [63:0] a_rsp_rdata;
    logic        b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [11:0] b_cmd_addr;
    logic [63:0] b_cmd_wdata;
    logic [7:0]  b_cmd_wmask;
    logic        b_rsp_valid;
    logic [63:0] b_rsp_rdata;
    logic [11:0] ram_addr;
    logic [63:0] ram_wr_data;
    logic        ram_wr_en;
    logic [63:0] ram_rd_data;

    itcm_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd_read(a_cmd_read),
        .a_cmd_addr(a_cmd_addr), .a_cmd_wdata(a_cmd_wdata), .a_cmd_wmask(a_cmd_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd_read(b_cmd_read),
        .b_cmd_addr(b_cmd_addr), .b_cmd_wdata(b_cmd_wdata), .b_cmd_wmask(b_cmd_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(int i);
        if (i == 16) return 64'h1122334455667788;
        if (i == 32) return 64'h1111111122222222;
        return {32'(i) * 32'h9E3779B1, ~32'(i) ^ 32'h5A5A0000};
    endfunction

    // Behavioural single-port RAM; preloaded on its first clock edge.
    logic [63:0] ram [4096];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
            ram_loaded  <= 1'b1;
            ram_rd_data <= '0;
        end else if (ram_wr_en) begin
            ram[ram_addr] <= ram_wr_data;
            ram_rd_data   <= ram_wr_data;
        end else begin
            ram_rd_data   <= ram[ram_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rst;
        logic        av; logic ar; logic [11:0] aa; logic [63:0] ad; logic [7:0] am;
        logic        bv; logic br; logic [11:0] ba; logic [63:0] bd; logic [7:0] bm;
    } stim_t;

    typedef struct { int due; bit rd; logic [63:0] d; } exp_rsp_t;

    logic [63:0] mm [4096];
    exp_rsp_t    qa[$], qb[$];
    bit          last_b, busy, addr_known;
    logic [11:0] m_addr, last_addr;
    logic [63:0] m_data, m_old;
    int          cyc = 0;
    int          n_pass = 0, n_total = 0;

    logic [16:0]  obs_c, exp_c;   // {a_rdy, b_rdy, a_rsp, b_rsp, wr_en, addr}
    logic [191:0] obs_d, exp_d;   // {a_rdata, b_rdata, wr_data}

    function automatic stim_t mk(bit rst,
                                 bit av, bit ar, logic [11:0] aa, logic [63:0] ad, logic [7:0] am,
                                 bit bv, bit br, logic [11:0] ba, logic [63:0] bd, logic [7:0] bm);
        stim_t s;
        s.rst = rst;
        s.av = av; s.ar = ar; s.aa = aa; s.ad = ad; s.am = am;
        s.bv = bv; s.br = br; s.ba = ba; s.bd = bd; s.bm = bm;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst_n       = !s.rst;
        a_cmd_valid = s.av; a_cmd_read = s.ar; a_cmd_addr = s.aa; a_cmd_wdata = s.ad; a_cmd_wmask = s.am;
        b_cmd_valid = s.bv; b_cmd_read = s.br; b_cmd_addr = s.ba; b_cmd_wdata = s.bd; b_cmd_wmask = s.bm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples the DUT at the falling edge and advances the model by one cycle.
    task automatic sample();
        bit          ga, gb, wr, ra, rb;
        logic [63:0] rda_e, rdb_e, rda_o, rdb_o, wd;
        logic [11:0] ad, ea;
        logic [63:0] wdat, nw;
        logic [7:0]  msk;
        bit          rd;
        exp_rsp_t    e;
        @(negedge clk);
        if (!rst_n) begin
            if (busy) mm[m_addr] = m_old;
            busy = 0; last_b = 1; addr_known = 0;
            qa.delete(); qb.delete();
            obs_c = {a_cmd_ready, b_cmd_ready, a_rsp_valid, b_rsp_valid, ram_wr_en, 12'h0};
            exp_c = '0; obs_d = '0; exp_d = '0;
            cyc++;
            return;
        end
        while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
        while (qb.size() > 0 && qb[0].due < cyc) void'(qb.pop_front());
        ra = qa.size() > 0 && qa[0].due == cyc;
        rb = qb.size() > 0 && qb[0].due == cyc;
        rda_e = (ra && qa[0].rd) ? qa[0].d : 64'h0;
        rda_o = (ra && qa[0].rd) ? a_rsp_rdata : 64'h0;
        rdb_e = (rb && qb[0].rd) ? qb[0].d : 64'h0;
        rdb_o = (rb && qb[0].rd) ? b_rsp_rdata : 64'h0;
        if (ra) void'(qa.pop_front());
        if (rb) void'(qb.pop_front());

        ga = 0; gb = 0; wr = 0; wd = '0; ea = last_addr;
        if (busy) begin
            wr = 1; wd = m_data; ea = m_addr; busy = 0;
        end else begin
            ga = a_cmd_valid && (!b_cmd_valid || last_b);
            gb = b_cmd_valid && !ga;
            if (ga || gb) begin
                rd = gb ? b_cmd_read : a_cmd_read;  ad = gb ? b_cmd_addr : a_cmd_addr;
                wdat = gb ? b_cmd_wdata : a_cmd_wdata; msk = gb ? b_cmd_wmask : a_cmd_wmask;
                last_b = gb; ea = ad;
                e.due = cyc + 1; e.rd = rd; e.d = '0;
                if (rd) begin
                    e.d = mm[ad];
                end else if (msk == 8'hFF) begin
                    mm[ad] = wdat; wr = 1; wd = wdat;
                end else if (msk != 8'h00) begin
                    nw = mm[ad];
                    for (int i = 0; i < 8; i++) if (msk[i]) nw[8*i +: 8] = wdat[8*i +: 8];
                    m_old = mm[ad]; mm[ad] = nw; m_addr = ad; m_data = nw; busy = 1;
                    e.due = cyc + 2;
                end
                if (gb) qb.push_back(e); else qa.push_back(e);
            end
        end
        if (busy || ga || gb || wr) addr_known = 1;
        exp_c = {ga, gb, ra, rb, wr, addr_known ? ea : 12'h0};
        obs_c = {a_cmd_ready, b_cmd_ready, a_rsp_valid, b_rsp_valid, ram_wr_en, addr_known ? ram_addr : 12'h0};
        exp_d = {rda_e, rdb_e, wr ? wd : 64'h0};
        obs_d = {rda_o, rdb_o, wr ? ram_wr_data : 64'h0};
        last_addr = ea;
        cyc++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        stim_t q[$];
        for (int i = 0; i < 4; i++) q.push_back(mk(1, 1,1,12'h001,64'h0,8'h00, 1,0,12'h002,64'h5,8'hFF));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL reset ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            tick();
        end
    endtask

    task automatic test_single_read();
        stim_t q[$];
        q.push_back(mk(0, 1,1,12'h010,64'h0,8'h00, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL single_read ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL single_read data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            if (i == 1) begin
                n_total++;
                if (a_rsp_rdata !== 64'h1122334455667788) $display("FAIL single_read rdata got %h want 1122334455667788", a_rsp_rdata);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_tie_alternate();
        stim_t q[$];
        for (int i = 0; i < 4; i++) q.push_back(mk(0, 1,1,12'(16+i),0,0, 1,1,12'(32+i),0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL tie_alternate ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL tie_alternate data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            tick();
        end
    endtask

    task automatic test_partial_write();
        stim_t q[$];
        q.push_back(mk(0, 0,0,0,0,0, 1,0,12'h020,64'hAAAAAAAABBBBBBBB,8'h0F));
        q.push_back(mk(0, 1,1,12'h020,0,0, 0,0,0,0,0));   // blocked by MERGE
        q.push_back(mk(0, 1,1,12'h020,0,0, 0,0,0,0,0));   // accepted right after MERGE
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL partial_write ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL partial_write data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            if (i == 1) begin
                n_total++;
                if (ram_wr_data !== 64'h11111111BBBBBBBB) $display("FAIL partial_write merge got %h want 11111111BBBBBBBB", ram_wr_data);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_wrap_full_write();
        stim_t q[$];
        q.push_back(mk(0, 1,0,12'hFFF,64'hFFFF0000FFFF0000,8'hFF, 0,0,0,0,0));
        q.push_back(mk(0, 1,1,12'hFFF,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL wrap_write ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL wrap_write data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            if (i == 2) begin
                n_total++;
                if (a_rsp_rdata !== 64'hFFFF0000FFFF0000) $display("FAIL wrap_write readback got %h want FFFF0000FFFF0000", a_rsp_rdata);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_mask_zero();
        stim_t q[$];
        q.push_back(mk(0, 0,0,0,0,0, 1,0,12'h005,64'hDEADBEEFCAFEF00D,8'h00));
        q.push_back(mk(0, 0,0,0,0,0, 1,1,12'h005,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL mask_zero ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL mask_zero data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid_rmw();
        stim_t q[$];
        q.push_back(mk(0, 1,0,12'h030,64'h0123456789ABCDEF,8'hF0, 0,0,0,0,0));
        q.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0));           // reset during MERGE
        q.push_back(mk(0, 1,1,12'h030,0,0, 1,1,12'h031,0,0)); // tie: A must win
        q.push_back(mk(0, 0,0,0,0,0, 1,1,12'h031,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL reset_mid_rmw ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL reset_mid_rmw data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        for (int i = 0; i < 6; i++)
            q.push_back(mk(0, 1,i[0],12'(64+i),{32'(i),32'hA5A5A5A5},8'hFF, 1,!i[0],12'(64+i),{32'hC3C3C3C3,32'(i)},8'hFF));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        q.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0));
        foreach (q[i]) begin
            drive(q[i]); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL back_to_back ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL back_to_back data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            tick();
        end
    endtask

    function automatic logic [7:0] rnd_mask();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    function automatic logic [11:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return 12'hFFF;
        return 12'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 400; i++) begin
            s = mk(i < 395 && $urandom_range(0, 79) == 0,
                   i < 395 && $urandom_range(0, 2) != 0, 1'($urandom), rnd_addr(), {$urandom, $urandom}, rnd_mask(),
                   i < 395 && $urandom_range(0, 2) != 0, 1'($urandom), rnd_addr(), {$urandom, $urandom}, rnd_mask());
            drive(s); sample();
            n_total++; if (obs_c !== exp_c) $display("FAIL random ctl cyc %0d got %h want %h", cyc, obs_c, exp_c); else n_pass++;
            n_total++; if (obs_d !== exp_d) $display("FAIL random data cyc %0d got %h want %h", cyc, obs_d, exp_d); else n_pass++;
            tick();
        end
        n_total++;
        if (qa.size() != 0 || qb.size() != 0) $display("FAIL random drain pending a=%0d b=%0d want 0", qa.size(), qb.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mm[i] = init_word(i);
        last_b = 1; busy = 0; addr_known = 0; last_addr = '0;
        m_addr = '0; m_data = '0; m_old = '0;
        drive(mk(1, 0,0,0,0,0, 0,0,0,0,0));
        tick();
        test_reset();
        test_single_read();
        test_tie_alternate();
        test_partial_write();
        test_wrap_full_write();
        test_mask_zero();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
